pipe_rca: RTL and testbench
===========================

PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter: STAGES, 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES, STAGES >= 1.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  operand set present.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 Port: sub  input  1  0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-013 Port: sum  output  WIDTH  result.
REQ-014 Port: cout  output  1  carry-out (add) / no-borrow (subtract).
REQ-015 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Operands SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 sub=0: {cout,sum} = a + b + cin; sub=1: {cout,sum} = a + ~b + !cin (i.e. a - b - cin).
REQ-018 ovf = carry into MSB XOR carry out of MSB.
REQ-019 Datapath split into STAGES slices of WIDTH/STAGES bits; stage k SHALL compute slice k using carry registered from stage k-1; upper-slice operands and lower-slice results SHALL be skewed by registers so one result is coherent at the output.
REQ-020 Latency: result SHALL appear with out_valid=1 exactly STAGES edges after acceptance when no stall occurs.
REQ-021 Throughput: one operation per cycle when out_ready is held high.
REQ-022 Stall: when out_valid && !out_ready, all pipeline registers (data and valid) SHALL hold; in_ready = out_ready || !out_valid.
REQ-023 sum/cout/ovf SHALL remain stable while out_valid && !out_ready.
REQ-024 Bubbles (in_valid=0) SHALL propagate as valid=0 stages; no result SHALL be produced for them.
REQ-025 Results SHALL leave in acceptance order; no loss, no duplication.
REQ-026 Wrap-around: unsigned overflow SHALL wrap modulo 2^WIDTH with cout reporting it; no saturation.
REQ-027 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder, latency 1.

Reset
REQ-028 While rst_n=0 at a rising edge, all stage valid bits, out_valid, sum, cout, ovf SHALL clear to 0.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after release.

Structure
REQ-031 Shared package rca_pkg SHALL hold the default WIDTH/STAGES constants and the slice-width derivation.
REQ-032 One combinational sub-module rca_slice (parametrised slice width; a, b, cin in; sum, cout, carry-into-MSB out) built as a full-adder ripple chain, instantiated STAGES times.
REQ-033 Elaboration SHALL fail when WIDTH mod STAGES != 0.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
REQ-035 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-037 8 back-to-back random vectors, out_ready low for 3 cycles starting at first out_valid -> in_ready low during stall, outputs held, all 8 results correct and in order.
REQ-038 rst_n low one cycle with 3 operations in flight -> out_valid=0 until a new operand is accepted and its 4-cycle latency elapses.
REQ-039 WIDTH=8, STAGES=1: a=0xF0, b=0x20, cin=1 -> next edge sum=0x11, cout=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
// Holds default geometry, slice-width derivation and the full-adder cell.
package rca_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipe_rca_if.sv
// Operand/result handshake bundle for pipe_rca (valid/ready on both sides).
// master = producer/consumer side, slave = the adder pipeline.
interface pipe_rca_if
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_slice.sv
// Combinational SW-bit full-adder ripple chain; zero latency, no handshake.
// Also exports the carry into its MSB so the top slice can derive signed overflow.
module rca_slice
  import rca_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
    cout = c[SW];
    cmsb = c[SW-1];
  end

endmodule

// File: rtl/pipe_rca.sv
// Pipelined add/subtract, STAGES slices of WIDTH/STAGES bits; latency STAGES edges, 1 op/cycle.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready = out_ready || !out_valid.
module pipe_rca
  import rca_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic       clk,
  input logic       rst_n,
  pipe_rca_if.slave bus
);

  localparam int SW   = slice_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_rca: WIDTH must be >= 2 and an integer multiple of STAGES >= 1");
  end

  logic             vld_q   [STAGES];
  logic             vld_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic [SW-1:0]    sl_s  [STAGES];
  logic             sl_co [STAGES];
  logic             sl_cm [STAGES];

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             advance;

  // Subtract is a + ~b + !cin, so the operand and carry are conditioned once at entry.
  always_comb begin
    b_in = (op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;
    c_in = bus.sub ^ bus.cin;
  end

  assign advance = bus.out_ready || !vld_q[LAST];

  // Operands of not-yet-added slices travel alongside the partial result.
  if (STAGES > 1) begin : g_skew
    logic [WIDTH-1:0] a_q [STAGES-1];
    logic [WIDTH-1:0] a_d [STAGES-1];
    logic [WIDTH-1:0] b_q [STAGES-1];
    logic [WIDTH-1:0] b_d [STAGES-1];

    always_comb begin
      for (int k = 0; k < STAGES - 1; k++) begin
        a_d[k] = a_q[k];
        b_d[k] = b_q[k];
      end
      if (advance) begin
        a_d[0] = bus.a;
        b_d[0] = b_in;
        for (int k = 1; k < STAGES - 1; k++) begin
          a_d[k] = a_q[k-1];
          b_d[k] = b_q[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [SW-1:0] op_a;
    logic [SW-1:0] op_b;
    logic          op_c;

    if (k == 0) begin : g_first
      assign op_a = bus.a[SW-1:0];
      assign op_b = b_in[SW-1:0];
      assign op_c = c_in;
    end else begin : g_next
      assign op_a = g_skew.a_q[k-1][k*SW +: SW];
      assign op_b = g_skew.b_q[k-1][k*SW +: SW];
      assign op_c = carry_q[k-1];
    end

    rca_slice #(
      .SW (SW)
    ) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_c),
      .sum  (sl_s[k]),
      .cout (sl_co[k]),
      .cmsb (sl_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k]   = vld_q[k];
      carry_d[k] = carry_q[k];
      sum_d[k]   = sum_q[k];
    end
    ovf_d = ovf_q;
    if (advance) begin
      vld_d[0]          = bus.in_valid;
      carry_d[0]        = sl_co[0];
      sum_d[0]          = '0;
      sum_d[0][SW-1:0]  = sl_s[0];
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]               = vld_q[k-1];
        carry_d[k]             = sl_co[k];
        sum_d[k]               = sum_q[k-1];
        sum_d[k][k*SW +: SW]   = sl_s[k];
      end
      // Signed overflow: carry into the word MSB differs from carry out of it.
      ovf_d = sl_cm[LAST] ^ sl_co[LAST];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rca.sv
// Bench for pipe_rca: 16-bit/4-stage main instance plus an 8-bit/1-stage instance.
// Expected results come from an integer-arithmetic model and a FIFO scoreboard.
module tb_pipe_rca;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int W8 = 8;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
  } op_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q [$];

  pipe_rca_if #(.WIDTH(W))  bus  ();
  pipe_rca_if #(.WIDTH(W8)) bus8 ();

  pipe_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pipe_rca #(.WIDTH(W8), .STAGES(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: true integer result, wrapped; signed range check for overflow.
  function automatic res_t model(input int w, input op_t op);
    longint m, ua, ub, ci, sa, sb, r, sr;
    res_t   res;
    m  = longint'(1) << w;
    ua = longint'(op.a);
    ub = longint'(op.b);
    ci = longint'(op.cin);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (op.sub) begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
    end else begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
    end
    res.sum  = 16'(r & (m - 1));
    res.cout = op.sub ? (r >= 0) : (r >= m);
    res.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    return res;
  endfunction

  function automatic op_t rand_op(input int w);
    op_t op;
    op.a   = 16'($urandom_range(0, (1 << w) - 1));
    op.b   = 16'($urandom_range(0, (1 << w) - 1));
    op.cin = 1'($urandom_range(0, 1));
    op.sub = 1'($urandom_range(0, 1));
    return op;
  endfunction

  task automatic drive(input logic v, input op_t op);
    bus.in_valid = v;
    bus.a        = op.a;
    bus.b        = op.b;
    bus.cin      = op.cin;
    bus.sub      = op.sub;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, '0);
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b sum=%h cout=%b ovf=%b, want all 0", bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    n_checks++;
    if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_w8: got vld=%b sum=%h, want 0", bus8.out_valid, bus8.sum);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed;
    op_t  ops   [6];
    res_t exp_r [6];
    res_t got;
    ops[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};  exp_r[0] = '{16'h0000, 1'b1, 1'b0};
    ops[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};  exp_r[1] = '{16'h8000, 1'b0, 1'b1};
    ops[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1};  exp_r[2] = '{16'hFFFE, 1'b0, 1'b0};
    ops[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1};  exp_r[3] = '{16'h7FFF, 1'b1, 1'b1};
    ops[4] = '{16'h0000, 16'h0000, 1'b1, 1'b1};  exp_r[4] = '{16'hFFFF, 1'b0, 1'b0};
    ops[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0};  exp_r[5] = '{16'h5556, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i]);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_in_ready[%0d]: got %b, want 1", i, bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int c = 1; c < S; c++) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL dir_early[%0d]: out_valid=%b at edge %0d, want 0", i, bus.out_valid, c);
        end
        @(posedge clk);
        #1;
      end
      got = {bus.sum, bus.cout, bus.ovf};
      n_checks++;
      if (bus.out_valid !== 1'b1 || got !== exp_r[i]) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got vld=%b sum=%h cout=%b ovf=%b, want vld=1 sum=%h cout=%b ovf=%b",
                 i, bus.out_valid, got.sum, got.cout, got.ovf, exp_r[i].sum, exp_r[i].cout, exp_r[i].ovf);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall;
    op_t        cur;
    res_t       exp_r, got;
    int         acc = 0, rcv = 0, cyc = 0, stall_left = -1;
    logic [17:0] held = '0;
    logic       have_held = 1'b0;
    logic       fire_in;
    exp_q.delete();
    cur = rand_op(W);
    drive(1'b1, cur);
    while (rcv < 8 && cyc < 100) begin
      if (stall_left < 0 && bus.out_valid === 1'b1) stall_left = 3;
      bus.out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b, want 0", bus.in_ready);
        end
        if (have_held) begin
          n_checks++;
          if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, held}) begin
            n_fail++;
            $display("FAIL stall_hold: got vld=%b {sum,cout,ovf}=%h, want vld=1 %h", bus.out_valid, {bus.sum, bus.cout, bus.ovf}, held);
          end
        end else begin
          held      = {bus.sum, bus.cout, bus.ovf};
          have_held = 1'b1;
        end
      end
      fire_in = bus.in_valid && bus.in_ready;
      if (fire_in) begin
        exp_q.push_back(model(W, cur));
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got = {bus.sum, bus.cout, bus.ovf};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_spurious: unexpected result sum=%h", got.sum);
        end else begin
          exp_r = exp_q.pop_front();
          if (got !== exp_r) begin
            n_fail++;
            $display("FAIL stall_result[%0d]: got %h/%b/%b, want %h/%b/%b", rcv, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
          end
        end
        rcv++;
      end
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
      if (fire_in) begin
        if (acc < 8) begin
          cur = rand_op(W);
          drive(1'b1, cur);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      cyc++;
    end
    n_checks++;
    if (rcv != 8 || stall_left != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_count: received %0d, stall_left %0d, pending %0d, want 8/0/0", rcv, stall_left, exp_q.size());
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    op_t  cur;
    res_t exp_r, got;
    int   acc = 0, rcv = 0, cyc = 0, first_out = -1, last_out = -1;
    logic fire_in;
    exp_q.delete();
    bus.out_ready = 1'b1;
    cur = rand_op(W);
    drive(1'b1, cur);
    while (rcv < 20 && cyc < 100) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready: got %b at cycle %0d, want 1", bus.in_ready, cyc);
      end
      fire_in = bus.in_valid && bus.in_ready;
      if (fire_in) begin
        exp_q.push_back(model(W, cur));
        acc++;
      end
      if (bus.out_valid === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got = {bus.sum, bus.cout, bus.ovf};
        n_checks++;
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (got !== exp_r) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h/%b/%b, want %h/%b/%b", rcv, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
        end
        rcv++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire_in) begin
        if (acc < 20) begin
          cur = rand_op(W);
          drive(1'b1, cur);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    n_checks++;
    if (first_out != S || last_out != first_out + 19 || rcv != 20) begin
      n_fail++;
      $display("FAIL b2b_timing: first=%0d last=%0d rcv=%0d, want first=%0d last=%0d rcv=20", first_out, last_out, rcv, S, S + 19);
    end
  endtask

  task automatic test_random;
    op_t  cur;
    res_t exp_r, got, prev;
    int   acc = 0, rcv = 0, cyc = 0;
    logic fire_in;
    logic prev_stall = 1'b0;
    exp_q.delete();
    prev = '0;
    cur  = rand_op(W);
    drive(1'b0, cur);
    while (rcv < 150 && cyc < 3000) begin
      if (!bus.in_valid && acc < 150 && $urandom_range(0, 3) != 0) begin
        cur = rand_op(W);
        drive(1'b1, cur);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      got = {bus.sum, bus.cout, bus.ovf};
      n_checks++;
      if (bus.in_ready !== (bus.out_ready || !bus.out_valid)) begin
        n_fail++;
        $display("FAIL rnd_in_ready: got %b with out_ready=%b out_valid=%b", bus.in_ready, bus.out_ready, bus.out_valid);
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || got !== prev) begin
          n_fail++;
          $display("FAIL rnd_hold: got vld=%b %h, want vld=1 %h", bus.out_valid, got, prev);
        end
      end
      fire_in = bus.in_valid && bus.in_ready;
      if (fire_in) begin
        exp_q.push_back(model(W, cur));
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        if (got !== exp_r) begin
          n_fail++;
          $display("FAIL rnd_result[%0d]: got %h/%b/%b, want %h/%b/%b", rcv, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
        end
        rcv++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = got;
      @(posedge clk);
      #1;
      cyc++;
      if (fire_in) bus.in_valid = 1'b0;
    end
    n_checks++;
    if (rcv != 150 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_count: received %0d pending %0d, want 150/0", rcv, exp_q.size());
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight;
    op_t  op;
    res_t exp_r, got;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_op(W));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flight_discard: out_valid=%b at cycle %0d after release, want 0", bus.out_valid, c);
      end
      @(posedge clk);
      #1;
    end
    op = rand_op(W);
    exp_r = model(W, op);
    drive(1'b1, op);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c < S; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flight_early: out_valid=%b at edge %0d, want 0", bus.out_valid, c);
      end
      @(posedge clk);
      #1;
    end
    got = {bus.sum, bus.cout, bus.ovf};
    n_checks++;
    if (bus.out_valid !== 1'b1 || got !== exp_r) begin
      n_fail++;
      $display("FAIL flight_new_result: got vld=%b %h/%b/%b, want vld=1 %h/%b/%b", bus.out_valid, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_w8s1;
    op_t  op;
    res_t exp_r, got;
    bus8.out_ready = 1'b1;
    bus8.a   = 8'hF0;
    bus8.b   = 8'h20;
    bus8.cin = 1'b1;
    bus8.sub = 1'b0;
    bus8.in_valid = 1'b1;
    n_checks++;
    if (bus8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_in_ready: got %b, want 1", bus8.in_ready);
    end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n_checks++;
    if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf} !== {1'b1, 8'h11, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL w8_directed: got vld=%b sum=%h cout=%b ovf=%b, want 1/11/1/0", bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf);
    end
    for (int i = 0; i < 12; i++) begin
      op = rand_op(W8);
      exp_r = model(W8, op);
      bus8.a = op.a[7:0];
      bus8.b = op.b[7:0];
      bus8.cin = op.cin;
      bus8.sub = op.sub;
      bus8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      got = {8'h00, bus8.sum, bus8.cout, bus8.ovf};
      n_checks++;
      if (bus8.out_valid !== 1'b1 || got !== exp_r) begin
        n_fail++;
        $display("FAIL w8_random[%0d]: got vld=%b %h/%b/%b, want vld=1 %h/%b/%b", i, bus8.out_valid, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
      end
    end
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_bubble: out_valid=%b after idle edge, want 0", bus8.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_w8s1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
